// File: rtl/cmp_result_tracker.sv
// Tracks qualified eq/lt/gt comparator results: saturating counters, gt streak, hysteretic alarm FSM.
// Optional: define CMP_TRACK_LATCH_EN to make the alarm latch until rst/clr.
module cmp_result_tracker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TRIP  = 3,
    parameter int unsigned CLEAR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    output logic [1:0]       state,
    output logic             alarm,
    output logic [WIDTH-1:0] gt_streak,
    output logic [WIDTH-1:0] eq_count,
    output logic [WIDTH-1:0] lt_count,
    output logic [WIDTH-1:0] gt_count,
    output logic             err
);

    localparam logic [1:0]       S_IDLE  = 2'b00;
    localparam logic [1:0]       S_ARMED = 2'b01;
    localparam logic [1:0]       S_ALARM = 2'b10;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TRIP_W  = WIDTH'(TRIP);
    localparam logic [WIDTH-1:0] CLEAR_W = WIDTH'(CLEAR);

    logic [1:0]       state_q, state_d;
    logic             alarm_q, alarm_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] gt_streak_q, gt_streak_d;
    logic [WIDTH-1:0] clr_streak_q, clr_streak_d;
    logic [WIDTH-1:0] eq_count_q, eq_count_d;
    logic [WIDTH-1:0] lt_count_q, lt_count_d;
    logic [WIDTH-1:0] gt_count_q, gt_count_d;

    logic             one_hot;
    logic             accept;
    logic [WIDTH-1:0] gt_streak_inc;
    logic [WIDTH-1:0] clr_streak_inc;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
        return (x == CNT_MAX) ? x : x + WIDTH'(1);
    endfunction

    // Next-state and counter update logic
    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        gt_streak_d    = gt_streak_q;
        clr_streak_d   = clr_streak_q;
        eq_count_d     = eq_count_q;
        lt_count_d     = lt_count_q;
        gt_count_d     = gt_count_q;
        one_hot        = ({eq, lt, gt} == 3'b100) || ({eq, lt, gt} == 3'b010) ||
                         ({eq, lt, gt} == 3'b001);
        accept         = in_valid && one_hot;
        gt_streak_inc  = sat_inc(gt_streak_q);
        clr_streak_inc = sat_inc(clr_streak_q);

        if (clr) begin
            state_d      = S_IDLE;
            err_d        = 1'b0;
            gt_streak_d  = '0;
            clr_streak_d = '0;
            eq_count_d   = '0;
            lt_count_d   = '0;
            gt_count_d   = '0;
        end else begin
            if (in_valid && !one_hot) begin
                err_d = 1'b1;
            end
            if (accept) begin
                if (eq) eq_count_d = sat_inc(eq_count_q);
                if (lt) lt_count_d = sat_inc(lt_count_q);
                if (gt) begin
                    gt_count_d   = sat_inc(gt_count_q);
                    gt_streak_d  = gt_streak_inc;
                    clr_streak_d = '0;
                end else begin
                    gt_streak_d  = '0;
                end
                case (state_q)
                    S_IDLE: begin
                        state_d = (gt && gt_streak_inc == TRIP_W) ? S_ALARM : S_ARMED;
                    end
                    S_ARMED: begin
                        if (gt && gt_streak_inc == TRIP_W) state_d = S_ALARM;
                    end
                    S_ALARM: begin
`ifdef CMP_TRACK_LATCH_EN
                        state_d = S_ALARM;
`else
                        if (!gt) begin
                            if (clr_streak_inc == CLEAR_W) begin
                                state_d      = S_ARMED;
                                clr_streak_d = '0;
                            end else begin
                                clr_streak_d = clr_streak_inc;
                            end
                        end
`endif
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            // Illegal encoding recovers regardless of sample qualification
            if (state_q == 2'b11) begin
                state_d = S_IDLE;
            end
`ifdef CMP_TRACK_LATCH_EN
            clr_streak_d = '0;
`else
            if (state_d != S_ALARM) clr_streak_d = '0;
`endif
        end
        alarm_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alarm_q      <= 1'b0;
            err_q        <= 1'b0;
            gt_streak_q  <= '0;
            clr_streak_q <= '0;
            eq_count_q   <= '0;
            lt_count_q   <= '0;
            gt_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            err_q        <= err_d;
            gt_streak_q  <= gt_streak_d;
            clr_streak_q <= clr_streak_d;
            eq_count_q   <= eq_count_d;
            lt_count_q   <= lt_count_d;
            gt_count_q   <= gt_count_d;
        end
    end

    assign state     = state_q;
    assign alarm     = alarm_q;
    assign err       = err_q;
    assign gt_streak = gt_streak_q;
    assign eq_count  = eq_count_q;
    assign lt_count  = lt_count_q;
    assign gt_count  = gt_count_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed self-checking bench for cmp_result_tracker (WIDTH=4, TRIP=3, CLEAR=2).
module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       eq = 1'b0;
    logic       lt = 1'b0;
    logic       gt = 1'b0;
    logic [1:0] state;
    logic       alarm;
    logic [3:0] gt_streak;
    logic [3:0] eq_count;
    logic [3:0] lt_count;
    logic [3:0] gt_count;
    logic       err;

    int checks   = 0;
    int failures = 0;

    cmp_result_tracker #(.WIDTH(4), .TRIP(3), .CLEAR(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .eq(eq), .lt(lt), .gt(gt),
        .state(state), .alarm(alarm), .gt_streak(gt_streak),
        .eq_count(eq_count), .lt_count(lt_count), .gt_count(gt_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic v, input logic e, input logic l, input logic g, input logic c);
        @(negedge clk);
        in_valid = v; eq = e; lt = l; gt = g; clr = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0; clr = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic al,
                           input logic [3:0] gs, input logic [3:0] ec, input logic [3:0] lc,
                           input logic [3:0] gc, input logic er);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".alarm"}, 32'(alarm), 32'(al));
        chk({tag, ".gt_streak"}, 32'(gt_streak), 32'(gs));
        chk({tag, ".eq_count"}, 32'(eq_count), 32'(ec));
        chk({tag, ".lt_count"}, 32'(lt_count), 32'(lc));
        chk({tag, ".gt_count"}, 32'(gt_count), 32'(gc));
        chk({tag, ".err"}, 32'(err), 32'(er));
    endtask

    initial begin
        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("idle_gap", 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Trip after three consecutive gt
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("trip1", 2'b01, 1'b0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("trip2", 2'b01, 1'b0, 4'd2, 4'd0, 4'd0, 4'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("trip3", 2'b10, 1'b1, 4'd3, 4'd0, 4'd0, 4'd3, 1'b0);

        // Clear hysteresis: lt, gt, lt, eq
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("clr_lt1", 2'b10, 1'b1, 4'd0, 4'd0, 4'd1, 4'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("clr_gt", 2'b10, 1'b1, 4'd1, 4'd0, 4'd1, 4'd4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("clr_lt2", 2'b10, 1'b1, 4'd0, 4'd0, 4'd2, 4'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CMP_TRACK_LATCH_EN
        chk_all("clr_eq", 2'b10, 1'b1, 4'd0, 4'd1, 4'd2, 4'd4, 1'b0);
`else
        chk_all("clr_eq", 2'b01, 1'b0, 4'd0, 4'd1, 4'd2, 4'd4, 1'b0);
`endif

        // Soft clear, then broken gt run with gaps
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("soft_clr", 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("brk1", 2'b01, 1'b0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("brk2", 2'b01, 1'b0, 4'd2, 4'd0, 4'd0, 4'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("brk3", 2'b01, 1'b0, 4'd0, 4'd1, 4'd0, 4'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("brk4", 2'b01, 1'b0, 4'd1, 4'd1, 4'd0, 4'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("brk5", 2'b01, 1'b0, 4'd2, 4'd1, 4'd0, 4'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("gap1", 2'b01, 1'b0, 4'd2, 4'd1, 4'd0, 4'd4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("gap2", 2'b01, 1'b0, 4'd2, 4'd1, 4'd0, 4'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("gap_trip", 2'b10, 1'b1, 4'd3, 4'd1, 4'd0, 4'd5, 1'b0);

        // Malformed samples set sticky err only
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("bad_eqgt", 2'b10, 1'b1, 4'd3, 4'd1, 4'd0, 4'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("bad_none", 2'b10, 1'b1, 4'd3, 4'd1, 4'd0, 4'd5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("err_sticky", 2'b10, 1'b1, 4'd3, 4'd1, 4'd0, 4'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("clr_drop", 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // eq counter saturation
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("eq_sat", 32'(eq_count), (i > 15) ? 32'd15 : 32'(i));
        end
        chk_all("eq_sat_end", 2'b01, 1'b0, 4'd0, 4'd15, 4'd0, 4'd0, 1'b0);

        // gt streak saturation while alarmed
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("gt_streak_sat", 32'(gt_streak), (i > 15) ? 32'd15 : 32'(i));
            chk("gt_sat_alarm", 32'(alarm), (i >= 3) ? 32'd1 : 32'd0);
        end
        chk_all("gt_sat_end", 2'b10, 1'b1, 4'd15, 4'd15, 4'd0, 4'd15, 1'b0);

        // rst wins over clr and a valid sample
        @(negedge clk);
        rst = 1'b1; clr = 1'b1; in_valid = 1'b1; lt = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; lt = 1'b0;
        chk_all("rst_prio", 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator's eq/lt/gt flags.
- Registers a qualified stream of compare results and keeps saturating per-outcome counters.
- Raises a debounced "A greater than B" alarm with trip/clear hysteresis.
- Feeds status/interrupt logic; the comparator stays purely combinational.

Parameters:
- WIDTH, 4, width of all counters and streak outputs.
- TRIP, 3, consecutive valid gt samples needed to raise alarm; legal range 1..2^WIDTH-1.
- CLEAR, 2, consecutive valid non-gt samples needed to drop alarm; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous soft clear of counters, err and FSM.
- in_valid  input  1  qualifies eq/lt/gt this cycle.
- eq  input  1  comparator a==b flag.
- lt  input  1  comparator a<b flag.
- gt  input  1  comparator a>b flag.
- state  output  2  FSM state: 00 IDLE, 01 ARMED, 10 ALARM.
- alarm  output  1  high while state==ALARM.
- gt_streak  output  WIDTH  current consecutive gt run, saturating.
- eq_count  output  WIDTH  total valid eq samples, saturating.
- lt_count  output  WIDTH  total valid lt samples, saturating.
- gt_count  output  WIDTH  total valid gt samples, saturating.
- err  output  1  sticky: a valid sample was not exactly one-hot.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all outputs 0, state=IDLE, internal clear-streak 0.
- Outputs are registered. A sample accepted on edge N is reflected in the outputs after edge N.
- Priority: rst > clr > sample.
  - clr=1: same result as reset except it takes effect only on a clk edge (it is already synchronous).
  - A sample presented in the same cycle as clr is dropped.
- Sample accepted only when in_valid=1 and exactly one of eq/lt/gt is 1.
- in_valid=0: no state, counter or streak change.
- Malformed sample (in_valid=1 and eq+lt+gt != 1):
  - Sets err=1; err stays set until rst or clr.
  - No counter, streak or FSM change.
- Counters: the matching count increments by 1 per accepted sample and holds at 2^WIDTH-1 (no wrap).
- gt_streak:
  - Increments, saturating, on an accepted gt.
  - Resets to 0 on an accepted eq or lt.
- Internal clear-streak (WIDTH bits):
  - Increments on an accepted non-gt while in ALARM.
  - Resets to 0 on an accepted gt.
  - Forced to 0 outside ALARM.
- FSM, accepted samples only:
  - IDLE: any accepted sample moves to ARMED, or directly to ALARM if it is gt and TRIP==1.
  - ARMED: gt whose post-increment streak == TRIP goes to ALARM; otherwise stay.
  - ALARM: non-gt whose post-increment clear-streak == CLEAR goes to ARMED, and clear-streak returns to 0; gt stays in ALARM.
  - IDLE is re-entered only via rst or clr.
- Saturated gt_streak in ALARM has no further effect.
- State 11 is unreachable. If it is ever entered, recover to IDLE on the next edge.

Optional Feature:
- Macro: CMP_TRACK_LATCH_EN.
- Defined: alarm latches. ALARM ignores the clear-streak and is left only by rst or clr; the internal clear-streak is held at 0.
- Undefined: auto-clear hysteresis as described in Behaviour.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release -> state=00, alarm=0, all counts 0, err=0.
2. Trip (TRIP=3): gt,gt,gt valid on consecutive cycles -> after 3rd edge state=10, alarm=1, gt_count=3, gt_streak=3; after 2nd edge alarm still 0.
3. Broken run: gt,gt,eq,gt,gt -> alarm stays 0; gt_streak goes 1,2,0,1,2; eq_count=1; in_valid=0 gap cycles change nothing.
4. Clear (CLEAR=2): from ALARM apply lt,gt,lt,eq -> alarm stays 1 through lt,gt,lt and falls after eq; state=01, gt_streak=0.
   - With CLEAR_TRACK latch macro, i.e. CMP_TRACK_LATCH_EN defined: alarm stays 1 until clr.
5. Malformed/clear: valid with eq=1,gt=1 -> err=1, counts unchanged. Then clr=1 together with a valid gt -> err=0, state=00, gt_count=0 (sample dropped).
6. Saturation (WIDTH=4): 17 valid eq samples -> eq_count=15 after 15th and stays 15; 20 valid gt samples -> gt_streak=15, alarm=1.
